// File: rtl/multicycle_ctrl_if.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl_if
//
// Purpose: bundles the opcode/memory-ready inputs and all datapath control
// outputs of the multicycle controller into one interface.
//
// Signals:
//   iOp          6  opcode field of the instruction register
//   iMemReady    1  memory access completes this cycle
//   oPCWrite     1  unconditional PC load
//   oPCWriteCond 1  PC load if ALU zero
//   oIorD        1  memory address select (0 = PC, 1 = ALUOut)
//   oMemRead     1  memory read request
//   oMemWrite    1  memory write request
//   oIRWrite     1  instruction register load
//   oMemtoReg    1  register write data (1 = MDR, 0 = ALUOut)
//   oRegDst      1  destination register (1 = rd, 0 = rt)
//   oRegWrite    1  register-file write
//   oALUSrcA     1  ALU A operand (0 = PC, 1 = rs)
//   oALUSrcB     2  ALU B operand (00 rt, 01 4, 10 imm, 11 imm<<2)
//   oALUOp       2  ALU control (00 add, 01 sub, 10 funct)
//   oPCSource    2  PC source (00 ALU, 01 ALUOut, 10 jump target)
//   oState       4  current state encoding, for debug
//   oIllegal     1  one-cycle pulse: unsupported opcode
//   oInstrDone   1  one-cycle pulse: last cycle of an instruction
//
// Modports:
//   slave  - the controller (consumes iOp/iMemReady, drives the controls)
//   master - the datapath/environment side
// ----------------------------------------------------------------------------
interface multicycle_ctrl_if;
    logic [5:0] iOp;
    logic       iMemReady;
    logic       oPCWrite;
    logic       oPCWriteCond;
    logic       oIorD;
    logic       oMemRead;
    logic       oMemWrite;
    logic       oIRWrite;
    logic       oMemtoReg;
    logic       oRegDst;
    logic       oRegWrite;
    logic       oALUSrcA;
    logic [1:0] oALUSrcB;
    logic [1:0] oALUOp;
    logic [1:0] oPCSource;
    logic [3:0] oState;
    logic       oIllegal;
    logic       oInstrDone;

    modport slave (
        input  iOp, iMemReady,
        output oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oIRWrite,
               oMemtoReg, oRegDst, oRegWrite, oALUSrcA, oALUSrcB, oALUOp,
               oPCSource, oState, oIllegal, oInstrDone
    );

    modport master (
        output iOp, iMemReady,
        input  oPCWrite, oPCWriteCond, oIorD, oMemRead, oMemWrite, oIRWrite,
               oMemtoReg, oRegDst, oRegWrite, oALUSrcA, oALUSrcB, oALUOp,
               oPCSource, oState, oIllegal, oInstrDone
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// multicycle_ctrl
//
// Purpose: Moore-style control FSM for a classic multicycle MIPS-like
// datapath. Supports lw, sw, R-type, beq and j; addi optionally.
// Only FETCH control signals and the MEMWR completion pulse depend on
// iMemReady; everything else is decoded from the state register.
//
// Ports:
//   iclk  in   clock, all state updates on the rising edge
//   irst  in   synchronous active-high reset; while high every control
//              output except oState is forced to 0
//   bus   slave modport of multicycle_ctrl_if (opcode, memory ready,
//              all datapath controls, debug state, illegal/done pulses)
//
// Build option:
//   MULTICYCLE_CTRL_ADDI_EN - when defined, adds the addi (001000) path
//   DECODE -> ADDIEX -> ADDIWB -> FETCH. When undefined, states 10/11 do
//   not exist and addi decodes as an illegal opcode.
// ----------------------------------------------------------------------------
module multicycle_ctrl (
    input  logic                  iclk,
    input  logic                  irst,
    multicycle_ctrl_if.slave      bus
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BEQ    = 4'd8,
        S_JUMP   = 4'd9
`ifdef MULTICYCLE_CTRL_ADDI_EN
        ,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
`endif
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
`ifdef MULTICYCLE_CTRL_ADDI_EN
    localparam logic [5:0] OP_ADDI  = 6'b001000;
`endif

    state_t     state_reg;
    state_t     state_next;

    // Raw decoded controls before the reset override.
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
    logic       instr_done;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge iclk) begin
        if (irst) begin
            state_reg <= S_FETCH;
        end else begin
            state_reg <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        state_next    = state_reg;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        iord          = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal       = 1'b0;
        instr_done    = 1'b0;

        case (state_reg)
            S_FETCH: begin
                // Fetch and PC+4 commit together only when the read lands,
                // so a stalled fetch leaves IR and PC untouched.
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = bus.iMemReady;
                pc_write  = bus.iMemReady;
                if (bus.iMemReady) begin
                    state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                // ALU precomputes the branch target into ALUOut.
                alu_src_b = 2'b11;
                case (bus.iOp)
                    OP_LW,
                    OP_SW:    state_next = S_MEMADR;
                    OP_RTYPE: state_next = S_EXEC;
                    OP_BEQ:   state_next = S_BEQ;
                    OP_J:     state_next = S_JUMP;
`ifdef MULTICYCLE_CTRL_ADDI_EN
                    OP_ADDI:  state_next = S_ADDIEX;
`else
                    // addi is not decoded in this build and falls through
                    // to the illegal-opcode path below.
`endif
                    default: begin
                        state_next = S_FETCH;
                        illegal    = 1'b1;
                        instr_done = 1'b1;
                    end
                endcase
            end

            S_MEMADR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                // Only lw/sw reach here; IR is frozen so iOp is stable.
                if (bus.iOp == OP_SW) begin
                    state_next = S_MEMWR;
                end else if (bus.iOp == OP_LW) begin
                    state_next = S_MEMRD;
                end else begin
                    state_next = S_FETCH;
                end
            end

            S_MEMRD: begin
                mem_read = 1'b1;
                iord     = 1'b1;
                if (bus.iMemReady) begin
                    state_next = S_MEMWB;
                end
            end

            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end

            S_MEMWR: begin
                mem_write = 1'b1;
                iord      = 1'b1;
                if (bus.iMemReady) begin
                    instr_done = 1'b1;
                    state_next = S_FETCH;
                end
            end

            S_EXEC: begin
                alu_src_a  = 1'b1;
                alu_op     = 2'b10;
                state_next = S_ALUWB;
            end

            S_ALUWB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end

            S_BEQ: begin
                alu_src_a     = 1'b1;
                alu_op        = 2'b01;
                pc_write_cond = 1'b1;
                pc_source     = 2'b01;
                instr_done    = 1'b1;
                state_next    = S_FETCH;
            end

            S_JUMP: begin
                pc_write   = 1'b1;
                pc_source  = 2'b10;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end

`ifdef MULTICYCLE_CTRL_ADDI_EN
            S_ADDIEX: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                alu_op     = 2'b00;
                state_next = S_ADDIWB;
            end

            S_ADDIWB: begin
                reg_write  = 1'b1;
                reg_dst    = 1'b0;
                mem_to_reg = 1'b0;
                instr_done = 1'b1;
                state_next = S_FETCH;
            end
`endif

            default: begin
                // Unused encodings drive nothing and fall back to FETCH.
                state_next = S_FETCH;
            end
        endcase

        // Reset overrides every control combinationally so a pending
        // memory write or register write is dropped in the cycle irst rises.
        if (irst) begin
            pc_write      = 1'b0;
            pc_write_cond = 1'b0;
            iord          = 1'b0;
            mem_read      = 1'b0;
            mem_write     = 1'b0;
            ir_write      = 1'b0;
            mem_to_reg    = 1'b0;
            reg_dst       = 1'b0;
            reg_write     = 1'b0;
            alu_src_a     = 1'b0;
            alu_src_b     = 2'b00;
            alu_op        = 2'b00;
            pc_source     = 2'b00;
            illegal       = 1'b0;
            instr_done    = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Interface outputs
    // ------------------------------------------------------------------
    assign bus.oPCWrite     = pc_write;
    assign bus.oPCWriteCond = pc_write_cond;
    assign bus.oIorD        = iord;
    assign bus.oMemRead     = mem_read;
    assign bus.oMemWrite    = mem_write;
    assign bus.oIRWrite     = ir_write;
    assign bus.oMemtoReg    = mem_to_reg;
    assign bus.oRegDst      = reg_dst;
    assign bus.oRegWrite    = reg_write;
    assign bus.oALUSrcA     = alu_src_a;
    assign bus.oALUSrcB     = alu_src_b;
    assign bus.oALUOp       = alu_op;
    assign bus.oPCSource    = pc_source;
    assign bus.oState       = state_reg;
    assign bus.oIllegal     = illegal;
    assign bus.oInstrDone   = instr_done;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// ----------------------------------------------------------------------------
// tb_multicycle_ctrl
//
// Directed bench for multicycle_ctrl. Each cycle: inputs are driven on the
// falling edge, outputs are checked 1 time unit later against hand-written
// control words, then the next rising edge advances the FSM.
//
// Control word packing (18 bits, MSB first):
//   PCWrite PCWriteCond IorD MemRead MemWrite IRWrite _
//   MemtoReg RegDst RegWrite ALUSrcA _ ALUSrcB[1:0] _ ALUOp[1:0] _
//   PCSource[1:0] _ Illegal InstrDone
// Build with +define+MULTICYCLE_CTRL_ADDI_EN to exercise the addi path.
// ----------------------------------------------------------------------------
module tb_multicycle_ctrl;

    logic clk;
    logic rst;

    multicycle_ctrl_if bus ();

    multicycle_ctrl dut (
        .iclk (clk),
        .irst (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    localparam logic [17:0] C_ZERO    = 18'b000000_0000_00_00_00_00;
    localparam logic [17:0] C_FETCH_R = 18'b100101_0000_01_00_00_00;
    localparam logic [17:0] C_FETCH_W = 18'b000100_0000_01_00_00_00;
    localparam logic [17:0] C_DECODE  = 18'b000000_0000_11_00_00_00;
    localparam logic [17:0] C_DEC_ILL = 18'b000000_0000_11_00_00_11;
    localparam logic [17:0] C_MEMADR  = 18'b000000_0001_10_00_00_00;
    localparam logic [17:0] C_MEMRD   = 18'b001100_0000_00_00_00_00;
    localparam logic [17:0] C_MEMWB   = 18'b000000_1010_00_00_00_01;
    localparam logic [17:0] C_MEMWR_W = 18'b001010_0000_00_00_00_00;
    localparam logic [17:0] C_MEMWR_D = 18'b001010_0000_00_00_00_01;
    localparam logic [17:0] C_EXEC    = 18'b000000_0001_00_10_00_00;
    localparam logic [17:0] C_ALUWB   = 18'b000000_0110_00_00_00_01;
    localparam logic [17:0] C_BEQ     = 18'b010000_0001_00_01_01_01;
    localparam logic [17:0] C_JUMP    = 18'b100000_0000_00_00_10_01;
`ifdef MULTICYCLE_CTRL_ADDI_EN
    localparam logic [17:0] C_ADDIEX  = 18'b000000_0001_10_00_00_00;
    localparam logic [17:0] C_ADDIWB  = 18'b000000_0010_00_00_00_01;
`endif

    logic [17:0] ctl;
    assign ctl = {bus.oPCWrite, bus.oPCWriteCond, bus.oIorD, bus.oMemRead,
                  bus.oMemWrite, bus.oIRWrite, bus.oMemtoReg, bus.oRegDst,
                  bus.oRegWrite, bus.oALUSrcA, bus.oALUSrcB, bus.oALUOp,
                  bus.oPCSource, bus.oIllegal, bus.oInstrDone};

    task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, settle, check state and control word, print.
    task automatic cyc(input string tag, input logic [5:0] op, input logic rdy,
                       input logic r, input logic [3:0] est, input logic [17:0] ectl);
        @(negedge clk);
        bus.iOp       = op;
        bus.iMemReady = rdy;
        rst           = r;
        #1;
        chk({tag, ".state"}, {14'd0, bus.oState}, {14'd0, est});
        chk({tag, ".ctl"}, ctl, ectl);
        $display("cyc %-10s op=%b rdy=%b rst=%b state=%0d ctl=%b", tag, op, rdy, r, bus.oState, ctl);
    endtask

    initial begin
        rst           = 1'b1;
        bus.iOp       = 6'b000000;
        bus.iMemReady = 1'b1;

        // First reset cycle: state not yet loaded, controls must still be 0.
        @(negedge clk);
        #1;
        chk("rst0.ctl", ctl, C_ZERO);
        $display("cyc %-10s ctl=%b", "rst0", ctl);
        // Reset held with iMemReady=1: FETCH state, but gating keeps all 0.
        cyc("rst1",     6'b000000, 1'b1, 1'b1, 4'd0, C_ZERO);

        // R-type
        cyc("r.fetch",  6'b000000, 1'b1, 1'b0, 4'd0, C_FETCH_R);
        cyc("r.decode", 6'b000000, 1'b1, 1'b0, 4'd1, C_DECODE);
        cyc("r.exec",   6'b000000, 1'b1, 1'b0, 4'd6, C_EXEC);
        cyc("r.aluwb",  6'b000000, 1'b1, 1'b0, 4'd7, C_ALUWB);

        // lw with a fetch stall and two MEMRD wait cycles
        cyc("lw.fwait", 6'b000000, 1'b0, 1'b0, 4'd0, C_FETCH_W);
        cyc("lw.fetch", 6'b000000, 1'b1, 1'b0, 4'd0, C_FETCH_R);
        cyc("lw.dec",   6'b100011, 1'b1, 1'b0, 4'd1, C_DECODE);
        cyc("lw.adr",   6'b100011, 1'b1, 1'b0, 4'd2, C_MEMADR);
        cyc("lw.rd0",   6'b100011, 1'b0, 1'b0, 4'd3, C_MEMRD);
        cyc("lw.rd1",   6'b100011, 1'b0, 1'b0, 4'd3, C_MEMRD);
        cyc("lw.rd2",   6'b100011, 1'b1, 1'b0, 4'd3, C_MEMRD);
        cyc("lw.wb",    6'b100011, 1'b1, 1'b0, 4'd4, C_MEMWB);

        // sw with one write wait
        cyc("sw.fetch", 6'b100011, 1'b1, 1'b0, 4'd0, C_FETCH_R);
        cyc("sw.dec",   6'b101011, 1'b1, 1'b0, 4'd1, C_DECODE);
        cyc("sw.adr",   6'b101011, 1'b1, 1'b0, 4'd2, C_MEMADR);
        cyc("sw.wr0",   6'b101011, 1'b0, 1'b0, 4'd5, C_MEMWR_W);
        cyc("sw.wr1",   6'b101011, 1'b1, 1'b0, 4'd5, C_MEMWR_D);

        // sw aborted by reset in its first MEMWR cycle
        cyc("swr.fetch",6'b101011, 1'b1, 1'b0, 4'd0, C_FETCH_R);
        cyc("swr.dec",  6'b101011, 1'b1, 1'b0, 4'd1, C_DECODE);
        cyc("swr.adr",  6'b101011, 1'b1, 1'b0, 4'd2, C_MEMADR);
        cyc("swr.wr",   6'b101011, 1'b0, 1'b1, 4'd5, C_ZERO);
        cyc("swr.after",6'b101011, 1'b0, 1'b0, 4'd0, C_FETCH_W);

        // beq
        cyc("beq.fetch",6'b101011, 1'b1, 1'b0, 4'd0, C_FETCH_R);
        cyc("beq.dec",  6'b000100, 1'b1, 1'b0, 4'd1, C_DECODE);
        cyc("beq.ex",   6'b000100, 1'b1, 1'b0, 4'd8, C_BEQ);

        // j
        cyc("j.fetch",  6'b000100, 1'b1, 1'b0, 4'd0, C_FETCH_R);
        cyc("j.dec",    6'b000010, 1'b1, 1'b0, 4'd1, C_DECODE);
        cyc("j.ex",     6'b000010, 1'b1, 1'b0, 4'd9, C_JUMP);

        // Illegal opcode 111111
        cyc("ill.fetch",6'b000010, 1'b1, 1'b0, 4'd0, C_FETCH_R);
        cyc("ill.dec",  6'b111111, 1'b1, 1'b0, 4'd1, C_DEC_ILL);

        // addi
        cyc("addi.fetch",6'b111111, 1'b1, 1'b0, 4'd0, C_FETCH_R);
`ifdef MULTICYCLE_CTRL_ADDI_EN
        cyc("addi.dec", 6'b001000, 1'b1, 1'b0, 4'd1, C_DECODE);
        cyc("addi.ex",  6'b001000, 1'b1, 1'b0, 4'd10, C_ADDIEX);
        cyc("addi.wb",  6'b001000, 1'b1, 1'b0, 4'd11, C_ADDIWB);
`else
        cyc("addi.dec", 6'b001000, 1'b1, 1'b0, 4'd1, C_DEC_ILL);
`endif
        cyc("end.fetch",6'b001000, 1'b0, 1'b0, 4'd0, C_FETCH_W);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/multicycle_ctrl.md
MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

Interface
REQ-001 The block SHALL have no parameters; the only build option is the macro in Configuration.
REQ-002 The block SHALL have one clock and a synchronous, active-high reset, with these ports:
- iclk  in  1  clock, all state on rising edge
- irst  in  1  synchronous active-high reset
- iOp  in  6  opcode field of the instruction register
- iMemReady  in  1  memory access completes this cycle
- oPCWrite  out  1  unconditional PC load
- oPCWriteCond  out  1  PC load if ALU zero
- oIorD  out  1  memory address select: 0 = PC, 1 = ALUOut
- oMemRead  out  1  memory read request
- oMemWrite  out  1  memory write request
- oIRWrite  out  1  instruction register load
- oMemtoReg  out  1  register-file write data: 1 = MDR, 0 = ALUOut
- oRegDst  out  1  destination register: 1 = rd, 0 = rt
- oRegWrite  out  1  register-file write
- oALUSrcA  out  1  ALU A operand: 0 = PC, 1 = rs
- oALUSrcB  out  2  ALU B operand: 00 = rt, 01 = 4, 10 = sign-extended immediate, 11 = shifted sign-extended immediate
- oALUOp  out  2  to ALU control unit: 00 = add, 01 = subtract, 10 = use funct
- oPCSource  out  2  PC source: 00 = ALU, 01 = ALUOut, 10 = jump target
- oState  out  4  current state encoding, for debug
- oIllegal  out  1  one-cycle pulse: unsupported opcode
- oInstrDone  out  1  one-cycle pulse: last cycle of an instruction

Function
REQ-003 The block SHALL be a Moore FSM with these states: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, ALUWB=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11.
REQ-004 State transitions SHALL be:
- FETCH -> DECODE when iMemReady=1, else stay in FETCH.
- DECODE -> MEMADR for lw 100011 or sw 101011; -> EXEC for R-type 000000; -> BEQ for 000100; -> JUMP for 000010.
- MEMADR -> MEMRD for lw, -> MEMWR for sw.
- MEMRD -> MEMWB when iMemReady=1, else stay.
- MEMWR -> FETCH when iMemReady=1, else stay.
- EXEC -> ALUWB.
- MEMWB, ALUWB, BEQ, JUMP -> FETCH.
REQ-005 Any opcode not listed in REQ-004 (or REQ-013) SHALL go DECODE -> FETCH with oIllegal=1 in that DECODE cycle.
REQ-006 Outputs SHALL be decoded from state only, except the iMemReady gating below; any output not listed for a state SHALL be 0:
- FETCH: MemRead=1, ALUSrcB=01, IRWrite=PCWrite=iMemReady.
- DECODE: ALUSrcB=11.
- MEMADR: ALUSrcA=1, ALUSrcB=10.
- MEMRD: MemRead=1, IorD=1.
- MEMWB: RegWrite=1, MemtoReg=1.
- MEMWR: MemWrite=1, IorD=1.
- EXEC: ALUSrcA=1, ALUOp=10.
- ALUWB: RegDst=1, RegWrite=1.
- BEQ: ALUSrcA=1, ALUOp=01, PCWriteCond=1, PCSource=01.
- JUMP: PCWrite=1, PCSource=10.
REQ-007 oInstrDone SHALL be 1 in MEMWB, ALUWB, BEQ and JUMP, in MEMWR when iMemReady=1, and in the illegal DECODE cycle.
REQ-008 Cycle counts with no memory wait SHALL be: lw 5, sw 4, R-type 4, beq 3, j 3.
REQ-009 Each cycle iMemReady=0 in FETCH, MEMRD or MEMWR SHALL add exactly one cycle, with the request held and no register-file or PC write.
REQ-010 iOp SHALL be sampled only in DECODE and MEMADR; it is stable because IRWrite=0 outside FETCH.

Reset
REQ-011 While irst=1, all outputs except oState SHALL be 0 regardless of state, and the state register SHALL load FETCH at the next edge.
REQ-012 Reset mid-instruction SHALL abort it with no partial write after the reset edge; a held MEMWR request SHALL drop in the same cycle irst rises.

Configuration
REQ-013 Macro MULTICYCLE_CTRL_ADDI_EN defined: addi (001000) SHALL take DECODE -> ADDIEX -> ADDIWB -> FETCH, with ADDIEX driving ALUSrcA=1, ALUSrcB=10, ALUOp=00 and ADDIWB driving RegWrite=1, RegDst=0, MemtoReg=0, oInstrDone=1.
REQ-014 Macro MULTICYCLE_CTRL_ADDI_EN undefined: states 10 and 11 SHALL NOT exist, 001000 SHALL be illegal per REQ-005, and any unreachable state encoding SHALL recover to FETCH next cycle.

Verification
REQ-015 The bench SHALL cover these directed scenarios:
- R-type 000000, iMemReady=1: states 0,1,6,7,0; oALUOp=10 in EXEC; RegWrite=RegDst=1 in ALUWB; oInstrDone once.
- lw 100011 with iMemReady=0 for 2 cycles in MEMRD: states 0,1,2,3,3,3,4,0; no RegWrite until MEMWB.
- sw 101011 with irst asserted in the first MEMWR cycle: oMemWrite=0 that cycle; state 0 next; no write.
- Opcode 111111: oIllegal=1 and oInstrDone=1 in DECODE; FETCH next; no PC or register write.
- addi 001000: with the macro, states 0,1,10,11,0 and RegWrite in ADDIWB; without it, oIllegal pulse.
